text_ram_arbiter: RTL
=====================

# text_ram_arbiter

Shares the single text RAM port between the display line fetcher and the parser's text controller. Display reads have priority. An optional starvation guard keeps parser edits moving, and a lock input makes parser read-modify-write sequences atomic against display traffic. Read data is returned to the owning requester with a fixed, known latency. The block sits between the text RAM and both clients; all RAM traffic passes through it.

## Interface
Parameters:
- READ_LATENCY, 2: RAM cycles from registered address to valid `ram_res`; range 1–4.
- STARVE_LIMIT, 8: consecutive waiting cycles for a ctrl request before it is forced through; range 1–255.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- disp_req  in  1  display read request.
- disp_addr  in  8  display row address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  `disp_rdata` valid.
- disp_rdata  out  TextRamResult_t  line read for display.
- ctrl_req  in  1  controller request.
- ctrl_ram_req  in  TextRamRequest_t  controller address, wren and data.
- ctrl_lock  in  1  keep controller ownership after the current grant.
- ctrl_gnt  out  1  controller request accepted this cycle.
- ctrl_rvalid  out  1  `ctrl_rdata` valid.
- ctrl_rdata  out  TextRamResult_t  line read for controller.
- ram_req  out  TextRamRequest_t  registered RAM request.
- ram_res  in  TextRamResult_t  RAM read data.
- debug  out  2  current state encoding.

## Operation
- States:
  - Idle: no owner.
  - Disp: display granted this cycle.
  - Ctrl: controller granted, unlocked.
  - Locked: controller owns the port.
- Arbitration is evaluated every cycle from the current state and the request inputs.
  - Locked: a ctrl request is granted. `disp_req` is never granted. Exit to Idle when `ctrl_lock` is sampled low with no ctrl grant.
  - Otherwise, both requests present: disp wins, unless the starve guard has fired.
  - Otherwise, a single request: that request wins.
- A ctrl grant with `ctrl_lock` = 1 moves to Locked.
- A grant is a one-cycle pulse. The requester may change its inputs on the next cycle.
- Ungranted requests must be held stable. The arbiter samples them again every cycle.
- Disp requests are always reads: `ram_req.wren` = 0 and `ram_req.data` is don't-care.
- Ctrl requests pass `ram_req.wren` and `ram_req.data` through unchanged.
- Read tagging: each granted read pushes an owner tag into a READ_LATENCY+1 deep shift pipe; writes push an empty tag.
  - At the pipe end, the owner's `rvalid` pulses and its `rdata` equals `ram_res`.
  - The other requester's `rdata` holds its last value.
- Arithmetic: the starve counter is 8-bit and saturates at STARVE_LIMIT; it never wraps.
- Reset mid-operation:
  - the tag pipe is cleared;
  - no `rvalid` fires for reads in flight;
  - `ram_req.wren` drops immediately, asynchronously.
- Reset values:
  - all outputs 0;
  - `ram_req` is all zero;
  - state is Idle;
  - the starve counter is 0.

## Timing
- Grant in cycle T: `ram_req` is registered at the end of T and valid in T+1.
- Read data: the owner's `rvalid` is high in cycle T+1+READ_LATENCY. With the default this is T+3.
- Throughput: one grant per cycle, back-to-back, to any mix of requesters.
- A write is visible in RAM for reads granted in T+1 or later.

## Configuration
- `TEXT_ARB_STARVE_GUARD_EN` defined:
  - the counter increments on each cycle with `ctrl_req` high and `ctrl_gnt` low;
  - at STARVE_LIMIT, the next contested cycle grants ctrl over disp;
  - the counter clears on any ctrl grant.
- Undefined: strict display priority, no counter, STARVE_LIMIT ignored.

## Structure
- Shared DataType.svh holds:
  - `TextRamRequest_t` and `TextRamResult_t` (existing);
  - an `ArbOwner_t` enum (None, Disp, Ctrl);
  - the `TEXT_ARB_DEFAULT_LATENCY` constant.
- Sub-module `text_ram_read_tracker`: a parameterised owner-tag shift pipe that outputs the tag at the end of the latency.

## Test plan
- Display only:
  - stimulus: `disp_req` with addr 5, 10, 11 on consecutive cycles;
  - required: three `disp_gnt` pulses and `disp_rvalid` at T+3, T+4, T+5 carrying rows 5, 10 and 11.
- Contention:
  - stimulus: both requesters request at T, ctrl is a write to row 3, guard off;
  - required: `disp_gnt` at T and `ctrl_gnt` at T+1, once `disp_req` is dropped;
  - required: `ram_req.wren` = 1 in T+2 with address 3.
- Starvation (guard on, STARVE_LIMIT = 4):
  - stimulus: `disp_req` held continuously while `ctrl_req` waits;
  - required: `ctrl_gnt` in the 5th waiting cycle, with display stalled for exactly that cycle.
- Lock:
  - stimulus: ctrl read of row 7 with `ctrl_lock` = 1, then `disp_req` in the next cycle, then a ctrl write of row 7, then `ctrl_lock` = 0;
  - required: display is not granted until the cycle after the unlock;
  - required: row 7 is written before the display read.
- Reset mid-read:
  - stimulus: `rst` pulsed at T+1 after a grant at T;
  - required: no `rvalid` afterwards, `debug` = 0, and all outputs 0.

Source files
------------

// File: rtl/text_ram_arbiter_pkg.sv
// Shared types for the text RAM arbiter: RAM request/result payloads, owner tags, FSM states.
package text_ram_arbiter_pkg;

  localparam int unsigned TEXT_ADDR_W              = 8;
  localparam int unsigned TEXT_DATA_W              = 32;
  localparam int unsigned TEXT_ARB_DEFAULT_LATENCY = 2;

  typedef struct packed {
    logic [TEXT_ADDR_W-1:0] addr;
    logic                   wren;
    logic [TEXT_DATA_W-1:0] data;
  } TextRamRequest_t;

  typedef struct packed {
    logic [TEXT_DATA_W-1:0] data;
  } TextRamResult_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_DISP = 2'd1,
    OWNER_CTRL = 2'd2
  } ArbOwner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DISP   = 2'd1,
    ST_CTRL   = 2'd2,
    ST_LOCKED = 2'd3
  } ArbState_t;

endpackage

// File: rtl/text_ram_arbiter_if.sv
// Bundle of display, controller and RAM-side signals around the text RAM arbiter.
interface text_ram_arbiter_if;
  import text_ram_arbiter_pkg::*;

  logic                   disp_req;
  logic [TEXT_ADDR_W-1:0] disp_addr;
  logic                   disp_gnt;
  logic                   disp_rvalid;
  TextRamResult_t         disp_rdata;

  logic                   ctrl_req;
  TextRamRequest_t        ctrl_ram_req;
  logic                   ctrl_lock;
  logic                   ctrl_gnt;
  logic                   ctrl_rvalid;
  TextRamResult_t         ctrl_rdata;

  TextRamRequest_t        ram_req;
  TextRamResult_t         ram_res;
  logic [1:0]             debug;

  modport slave (
    input  disp_req, disp_addr, ctrl_req, ctrl_ram_req, ctrl_lock, ram_res,
    output disp_gnt, disp_rvalid, disp_rdata, ctrl_gnt, ctrl_rvalid, ctrl_rdata, ram_req, debug
  );

  modport master (
    output disp_req, disp_addr, ctrl_req, ctrl_ram_req, ctrl_lock, ram_res,
    input  disp_gnt, disp_rvalid, disp_rdata, ctrl_gnt, ctrl_rvalid, ctrl_rdata, ram_req, debug
  );

endinterface

// File: rtl/text_ram_arbiter_read_tracker.sv
// Owner-tag shift pipe: the tag pushed with a grant emerges DEPTH cycles later.
module text_ram_read_tracker
  import text_ram_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = TEXT_ARB_DEFAULT_LATENCY + 1
) (
  input  logic      clk,
  input  logic      rst,
  input  ArbOwner_t tag_i,
  output ArbOwner_t tag_o
);

  ArbOwner_t pipe_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= OWNER_NONE;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/text_ram_arbiter.sv
// Arbitrates the text RAM port between display reads and controller accesses.
// Optional starvation guard for the controller: define TEXT_ARB_STARVE_GUARD_EN.
module text_ram_arbiter
  import text_ram_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = TEXT_ARB_DEFAULT_LATENCY,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                clk,
  input logic                rst,
  text_ram_arbiter_if.slave  bus
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_param_check
    $error("text_ram_arbiter: parameter out of range");
  end

  ArbState_t       state_q, state_d;
  TextRamRequest_t ram_req_q, ram_req_d;
  TextRamResult_t  disp_hold_q, ctrl_hold_q;
  ArbOwner_t       owner_c, tag_end;
  logic            disp_gnt_c, ctrl_gnt_c, starve_fire_c;
  logic            disp_rvalid_c, ctrl_rvalid_c;

`ifdef TEXT_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  logic [7:0] starve_q, starve_d;

  // Counts cycles the controller waits; saturates, cleared by any ctrl grant.
  always_comb begin
    starve_d = starve_q;
    if (ctrl_gnt_c)                                starve_d = 8'd0;
    else if (bus.ctrl_req && starve_q < STARVE_MAX) starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= 8'd0;
    else     starve_q <= starve_d;
  end

  assign starve_fire_c = (starve_q >= STARVE_MAX);
`else
  assign starve_fire_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ctrl_gnt_c)                                   state_d = bus.ctrl_lock ? ST_LOCKED : ST_CTRL;
    else if (disp_gnt_c)                              state_d = ST_DISP;
    else if (state_q != ST_LOCKED || !bus.ctrl_lock) state_d = ST_IDLE;
  end

  // Grant decision, RAM request to register and the owner tag for the read pipe.
  always_comb begin
    disp_gnt_c = 1'b0;
    ctrl_gnt_c = 1'b0;
    owner_c    = OWNER_NONE;
    ram_req_d  = '0;
    if (state_q == ST_LOCKED) begin
      ctrl_gnt_c = bus.ctrl_req;
    end else if (bus.ctrl_req && (!bus.disp_req || starve_fire_c)) begin
      ctrl_gnt_c = 1'b1;
    end else begin
      disp_gnt_c = bus.disp_req;
    end
    if (disp_gnt_c) begin
      ram_req_d.addr = bus.disp_addr;
      owner_c        = OWNER_DISP;
    end else if (ctrl_gnt_c) begin
      ram_req_d = bus.ctrl_ram_req;
      owner_c   = bus.ctrl_ram_req.wren ? OWNER_NONE : OWNER_CTRL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_req_q <= '0;
    else     ram_req_q <= ram_req_d;
  end

  text_ram_read_tracker #(
    .DEPTH (READ_LATENCY + 1)
  ) u_tracker (
    .clk   (clk),
    .rst   (rst),
    .tag_i (owner_c),
    .tag_o (tag_end)
  );

  assign disp_rvalid_c = (tag_end == OWNER_DISP);
  assign ctrl_rvalid_c = (tag_end == OWNER_CTRL);

  // The non-owning requester keeps its last returned line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_hold_q <= '0;
      ctrl_hold_q <= '0;
    end else begin
      if (disp_rvalid_c) disp_hold_q <= bus.ram_res;
      if (ctrl_rvalid_c) ctrl_hold_q <= bus.ram_res;
    end
  end

  assign bus.disp_gnt    = disp_gnt_c;
  assign bus.ctrl_gnt    = ctrl_gnt_c;
  assign bus.disp_rvalid = disp_rvalid_c;
  assign bus.ctrl_rvalid = ctrl_rvalid_c;
  assign bus.disp_rdata  = disp_rvalid_c ? bus.ram_res : disp_hold_q;
  assign bus.ctrl_rdata  = ctrl_rvalid_c ? bus.ram_res : ctrl_hold_q;
  assign bus.ram_req     = ram_req_q;
  assign bus.debug       = 2'(state_q);

endmodule
